// File: rtl/sr_cmd_gen.sv
// Debounced set/clear request front end driving one-cycle S/R commands into an SR latch,
// with clear priority, one-deep pending per direction and a fixed hold-off after each command.
module sr_cmd_gen #(
  parameter int DB_CYCLES      = 4,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic clr_in,
  output logic S,
  output logic R,
  output logic en,
  output logic busy,
  output logic conflict
);

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, HOLDOFF} state_t;

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);
  localparam logic [7:0] HO_LAST = 8'(HOLDOFF_CYCLES - 1);

  // Bit 0 carries the set path, bit 1 the clear path.
  logic [1:0] w_raw;
  logic [1:0] r_sync_p0;
  logic [1:0] r_sync_p1;
  logic [1:0] r_lvl_p2;
  logic [1:0] r_lvl_d;
  logic [1:0] r_req_p3;
  logic [7:0] r_cnt [2];

  assign w_raw = {clr_in, set_in};

  // p0/p1: two-flop synchronizers, p2: debounced level, p3: registered rising-edge request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_lvl_p2  <= '0;
      r_lvl_d   <= '0;
      r_req_p3  <= '0;
      r_cnt[0]  <= '0;
      r_cnt[1]  <= '0;
    end else begin
      r_sync_p0 <= w_raw;
      r_sync_p1 <= r_sync_p0;
      r_lvl_d   <= r_lvl_p2;
      r_req_p3  <= r_lvl_p2 & ~r_lvl_d;
      for (int i = 0; i < 2; i++) begin
        if (r_sync_p1[i] == r_lvl_p2[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_lvl_p2[i] <= ~r_lvl_p2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_hcnt;
  logic       r_pend_s;
  logic       r_pend_r;
  logic       w_want_s;
  logic       w_want_r;
  logic       w_decide;
  logic       w_s;
  logic       w_r;
  logic       w_en;
  logic       w_busy;
  logic       w_conf;

  assign w_want_s = r_req_p3[0] | r_pend_s;
  assign w_want_r = r_req_p3[1] | r_pend_r;
  // The last hold-off cycle makes the same decision IDLE would, so busy never drops between
  // back-to-back commands.
  assign w_decide = (r_state == IDLE) || ((r_state == HOLDOFF) && (r_hcnt == HO_LAST));

  always_comb begin
    w_next = r_state;
    case (r_state)
      PULSE_S, PULSE_R: w_next = HOLDOFF;
      default: begin
        if (w_decide) begin
          if (w_want_r)      w_next = PULSE_R;
          else if (w_want_s) w_next = PULSE_S;
          else               w_next = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_s    = (w_next == PULSE_S);
    w_r    = (w_next == PULSE_R);
    w_en   = w_s | w_r;
    w_busy = (w_next != IDLE);
    w_conf = w_decide & w_want_r & w_want_s;
  end

  // FSM state and registered command outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_hcnt   <= '0;
      r_pend_s <= 1'b0;
      r_pend_r <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      en       <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hcnt  <= ((r_state == HOLDOFF) && (w_next == HOLDOFF)) ? r_hcnt + 8'd1 : 8'd0;
      if (w_decide) begin
        r_pend_s <= 1'b0;
        r_pend_r <= 1'b0;
      end else begin
        r_pend_s <= r_pend_s | r_req_p3[0];
        r_pend_r <= r_pend_r | r_req_p3[1];
      end
      S        <= w_s;
      R        <= w_r;
      en       <= w_en;
      busy     <= w_busy;
      conflict <= w_conf;
    end
  end

endmodule

// File: doc/sr_cmd_gen.md
SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable synchronized cycles needed to accept a new input level (legal range 1..255).
REQ-002 Parameter HOLDOFF_CYCLES, default 2: idle cycles forced after every issued command (legal range 1..255).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 set_in  input  1  raw asynchronous set request, such as a button.
REQ-006 clr_in  input  1  raw asynchronous clear request.
REQ-007 S  output  1  registered set command to the downstream SR latch.
REQ-008 R  output  1  registered reset command to the downstream SR latch.
REQ-009 en  output  1  registered latch enable; high only in a cycle carrying a command.
REQ-010 busy  output  1  registered; high whenever the FSM is not in IDLE.
REQ-011 conflict  output  1  registered one-cycle pulse when set and clear requests collide.

Function
REQ-012 Each raw input SHALL pass through a dedicated two-flop synchronizer before any other logic.
REQ-013 Each synchronized input SHALL have a debouncer: an 8-bit counter that clears whenever the synchronized value equals the debounced level, otherwise increments; the debounced level toggles and the counter clears when the count reaches DB_CYCLES-1 and the value still differs.
REQ-014 A request SHALL be a 0->1 transition of a debounced level, detected as a one-cycle pulse; 1->0 transitions generate nothing.
REQ-015 The FSM SHALL have exactly four states: IDLE, PULSE_S, PULSE_R and HOLDOFF.
REQ-016 IDLE: set request or pending set only -> PULSE_S; clear request or pending clear present -> PULSE_R; otherwise stay in IDLE.
REQ-017 A set and a clear request in the same cycle (new or pending) SHALL select PULSE_R (clear priority), discard the set, and pulse conflict for one cycle.
REQ-018 PULSE_S SHALL drive S=1, R=0, en=1 for exactly one cycle, then go to HOLDOFF; PULSE_R SHALL drive S=0, R=1, en=1 for exactly one cycle, then go to HOLDOFF.
REQ-019 HOLDOFF SHALL last exactly HOLDOFF_CYCLES cycles with S=R=en=0, then return to IDLE.
REQ-020 Requests arriving in PULSE_S, PULSE_R or HOLDOFF SHALL set a one-deep pending flag per direction, and additional requests of the same direction SHALL be dropped.
REQ-021 Pending requests SHALL be served from IDLE under the same rules as REQ-016 and REQ-017, and a pending flag SHALL clear when its command issues or is discarded.
REQ-022 S=1 together with R=1 SHALL never occur, and en SHALL never be high without exactly one of S or R high.
REQ-023 Latency: with a raw input held high from rising edge N, the command (S or R with en) SHALL be high in cycle N+DB_CYCLES+3, provided the FSM is in IDLE.
REQ-024 The minimum spacing between two commands SHALL be HOLDOFF_CYCLES+1 cycles.

Reset
REQ-025 While rst is high at a clock edge, all synchronizers, debounced levels, counters, pending flags and edge detectors SHALL clear, the FSM SHALL enter IDLE, and S, R, en, busy and conflict SHALL be 0.
REQ-026 rst asserted mid-command or mid-HOLDOFF SHALL abort the sequence, with no command issued in the following cycle.
REQ-027 A raw input held high through reset SHALL produce exactly one request after release, following REQ-023 timing counted from the first post-reset edge.

Verification
REQ-028 DB_CYCLES=4, HOLDOFF_CYCLES=2, set_in rises and holds -> S=1, en=1 for one cycle at edge N+7; busy high for 3 cycles; then idle.
REQ-029 set_in glitch high for 3 synchronized cycles then low -> no S, R or en activity ever.
REQ-030 set_in and clr_in rise on the same edge -> one cycle of R=1, en=1 with conflict=1, and no S pulse afterwards.
REQ-031 clr_in rises during HOLDOFF of a set command -> R pulse issued exactly in the first IDLE cycle after HOLDOFF completes, and busy stays high throughout.
REQ-032 rst pulsed in the PULSE_S cycle -> all outputs 0 on the next edge; with set_in still high, one new S pulse DB_CYCLES+3 cycles after release.
REQ-033 Random raw stimulus for 10^5 cycles -> assertion that S and R are never both high, and that en is always equal to S XOR R.
